// File: rtl/rip_stim_check.sv
// Exhaustive stimulus generator and checker for a ripple carry adder.
// Sweeps every {cin, b, a} vector, waits SETTLE cycles, then compares {cout, sum} to a+b+cin.
module rip_stim_check #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  output logic               cin_o,
  input  logic [WIDTH-1:0]   sum_i,
  input  logic               cout_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH+1:0] err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic               fail_cin
);

  localparam int unsigned VecW = 2 * WIDTH + 1;
  localparam int unsigned ErrW = 2 * WIDTH + 2;
  localparam int unsigned CntW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CntW-1:0] SettleLd = CntW'(SETTLE);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  state_e            state_q, state_d;
  logic [VecW-1:0]   vec_q, vec_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ErrW-1:0]   err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [WIDTH-1:0]  fail_a_q, fail_a_d;
  logic [WIDTH-1:0]  fail_b_q, fail_b_d;
  logic              fail_cin_q, fail_cin_d;

  logic [WIDTH:0]    ref_sum;
  logic              mismatch;

  // Full-width reference so a missing carry-out is caught.
  assign ref_sum  = {1'b0, vec_q[WIDTH-1:0]} + {1'b0, vec_q[2*WIDTH-1:WIDTH]}
                  + {{WIDTH{1'b0}}, vec_q[2*WIDTH]};
  assign mismatch = ({cout_i, sum_i} != ref_sum);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    fail_cin_d = fail_cin_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          vec_d      = '0;
          err_d      = '0;
          fail_a_d   = '0;
          fail_b_d   = '0;
          fail_cin_d = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          cnt_d      = SettleLd;
          state_d    = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StCheck: begin
        if (mismatch) begin
          err_d = err_q + ErrW'(1);
          if (err_q == '0) begin
            fail_a_d   = vec_q[WIDTH-1:0];
            fail_b_d   = vec_q[2*WIDTH-1:WIDTH];
            fail_cin_d = vec_q[2*WIDTH];
          end
        end
        if (&vec_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = StDone;
        end else begin
          vec_d   = vec_q + VecW'(1);
          cnt_d   = SettleLd;
          state_d = StSettle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      vec_q      <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_cin_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      fail_cin_q <= fail_cin_d;
    end
  end

  assign a_o       = vec_q[WIDTH-1:0];
  assign b_o       = vec_q[2*WIDTH-1:WIDTH];
  assign cin_o     = vec_q[2*WIDTH];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_cin  = fail_cin_q;

endmodule

// File: tb/tb_rip_stim_check.sv
// Bench for rip_stim_check: drives two instances (SETTLE=1 and SETTLE=3) against adder models
// with selectable faults; expected sweep results go through a scoreboard queue.
module tb_rip_stim_check;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 1: SETTLE=1, adder model selected by mode1.
  logic       start1 = 1'b0;
  logic [3:0] a1, b1, sum1, fail_a1, fail_b1;
  logic       cin1, cout1, busy1, done1, pass1, fail_cin1;
  logic [9:0] err1;
  int         mode1 = 0;

  // Instance 3: SETTLE=3, adder outputs always delayed three cycles.
  logic       start3 = 1'b0;
  logic [3:0] a3, b3, sum3, fail_a3, fail_b3;
  logic       cin3, cout3, busy3, done3, pass3, fail_cin3;
  logic [9:0] err3;

  rip_stim_check #(.WIDTH(4), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a_o(a1), .b_o(b1), .cin_o(cin1), .sum_i(sum1), .cout_i(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_a(fail_a1), .fail_b(fail_b1), .fail_cin(fail_cin1)
  );

  rip_stim_check #(.WIDTH(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .a_o(a3), .b_o(b3), .cin_o(cin3), .sum_i(sum3), .cout_i(cout3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_a(fail_a3), .fail_b(fail_b3), .fail_cin(fail_cin3)
  );

  logic [4:0] ref1, out1, ref3;
  logic [4:0] p1a = '0, p1b = '0, p1c = '0;
  logic [4:0] p3a = '0, p3b = '0, p3c = '0;

  assign ref1 = {1'b0, a1} + {1'b0, b1} + {4'b0, cin1};
  assign ref3 = {1'b0, a3} + {1'b0, b3} + {4'b0, cin3};

  always @(posedge clk) begin
    p1a <= ref1; p1b <= p1a; p1c <= p1b;
    p3a <= ref3; p3b <= p3a; p3c <= p3b;
  end

  always_comb begin
    case (mode1)
      1:       out1 = ref1 & 5'b11110;  // sum bit0 stuck at 0
      2:       out1 = ref1 & 5'b01111;  // carry-out stuck at 0
      3:       out1 = p1c;              // three-cycle delayed adder
      default: out1 = ref1;
    endcase
  end
  assign {cout1, sum1} = out1;
  assign {cout3, sum3} = p3c;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  always @(negedge clk) begin
    if ((busy1 && done1) || (busy3 && done3)) overlap <= overlap + 1;
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int err;
    bit err_any;
    bit pass;
    int fa;
    int fb;
    int fc;
    int cycles;
  } exp_t;

  exp_t sb_q[$];
  int unsigned t0;

  // Independent reference: replay the sweep against the fault model.
  function automatic exp_t model(input int mode, input int settle);
    exp_t e;
    e.err = 0; e.err_any = 0; e.fa = 0; e.fb = 0; e.fc = 0;
    e.cycles = 512 * (settle + 1);
    if (mode == 3) begin
      e.err_any = 1;
      e.pass    = 0;
      return e;
    end
    for (int v = 0; v < 512; v++) begin
      int a, b, c, r, g;
      a = v % 16;
      b = (v / 16) % 16;
      c = v / 256;
      r = a + b + c;
      g = r;
      if (mode == 1) g = r & 30;
      if (mode == 2) g = r & 15;
      if (g != r) begin
        if (e.err == 0) begin
          e.fa = a; e.fb = b; e.fc = c;
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
    t0 = cyc;
  endtask

  task automatic launch(input int sel, input int mode);
    sb_q.push_back(model(mode, (sel == 3) ? 3 : 1));
    pulse_start(sel);
  endtask

  task automatic wait_and_compare(input int sel, input int limit);
    exp_t e;
    logic dn;
    dn = (sel == 3) ? done3 : done1;
    while (!dn && (cyc - t0) < limit) begin
      @(negedge clk);
      dn = (sel == 3) ? done3 : done1;
    end
    check_eq("done_within_bound", dn, 1);
    e = sb_q.pop_front();
    check_eq("run_cycles", cyc - t0, e.cycles);
    check_eq("busy_at_done", (sel == 3) ? busy3 : busy1, 0);
    check_eq("pass", (sel == 3) ? pass3 : pass1, e.pass);
    if (e.err_any) begin
      check_eq("err_nonzero", (((sel == 3) ? err3 : err1) != 0), 1);
    end else begin
      check_eq("err_count", (sel == 3) ? err3 : err1, e.err);
      check_eq("fail_a", (sel == 3) ? fail_a3 : fail_a1, e.fa);
      check_eq("fail_b", (sel == 3) ? fail_b3 : fail_b1, e.fb);
      check_eq("fail_cin", (sel == 3) ? fail_cin3 : fail_cin1, e.fc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_a"}, {a1, b1, cin1}, 0);
    check_eq({tag, "_flags"}, {busy1, done1, pass1}, 0);
    check_eq({tag, "_err"}, err1, 0);
    check_eq({tag, "_fail"}, {fail_a1, fail_b1, fail_cin1}, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    check_eq("reset_dut3", {busy3, done3, pass3, err3, a3, b3, cin3}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_no_activity", {busy1, a1}, 0);

    // Good adder: first vector and busy appear on the start edge.
    mode1 = 0;
    launch(1, 0);
    check_eq("busy_after_start", busy1, 1);
    check_eq("vec0_applied", {cin1, b1, a1}, 0);
    wait_and_compare(1, 3000);

    // sum bit0 stuck at 0.
    mode1 = 1;
    launch(1, 1);
    wait_and_compare(1, 3000);

    // Restart from DONE clears the failing results.
    mode1 = 0;
    launch(1, 0);
    check_eq("restart_busy", busy1, 1);
    check_eq("restart_done", done1, 0);
    check_eq("restart_err", err1, 0);
    check_eq("restart_fail", {fail_a1, fail_b1, fail_cin1}, 0);
    check_eq("restart_vec", {cin1, b1, a1}, 0);
    wait_and_compare(1, 3000);

    // Carry-out stuck at 0.
    mode1 = 2;
    launch(1, 2);
    wait_and_compare(1, 3000);

    // Start during a sweep is ignored; run length is unchanged.
    mode1 = 0;
    launch(1, 0);
    repeat (198) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check_eq("midstart_vec_continues", {cin1, b1, a1} > 50, 1);
    check_eq("midstart_busy", busy1, 1);
    wait_and_compare(1, 3000);

    // Asynchronous reset mid-sweep.
    pulse_start(1);
    repeat (300) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_all_zero("post_reset_idle");

    // Slow adder: enough settle time passes, too little fails.
    launch(3, 0);
    wait_and_compare(3, 5000);
    mode1 = 3;
    launch(1, 3);
    wait_and_compare(1, 3000);

    check_eq("busy_done_exclusive", overlap, 0);
    check_eq("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
